// File: rtl/sum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sum_arbiter
// Purpose  : Round-robin scheduler sharing one registered `sum` adder between
//            N_REQ requesters. Results return through a credit-protected FIFO
//            tagged with the issuing requester ID.
// Options  : SUM_ARB_OVF_EN - adds carry-out storage and the resp_ovf port
// Revision : 1.0 - initial release
// ============================================================================
module sum_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int SUM_LAT   = 1,
  parameter int RES_DEPTH = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       sum_a,
  output logic [WIDTH-1:0]       sum_b,
  input  logic [WIDTH-1:0]       sum_c,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_c
`ifdef SUM_ARB_OVF_EN
  ,
  output logic                   resp_ovf
`endif
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
`ifdef SUM_ARB_OVF_EN
  localparam int ENT_W = 1 + ID_W + WIDTH;
`else
  localparam int ENT_W = ID_W + WIDTH;
`endif

  // Registered state
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [WIDTH-1:0] sum_a_q, sum_a_d;
  logic [WIDTH-1:0] sum_b_q, sum_b_d;
  logic [SUM_LAT:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]  tag_id_q [SUM_LAT+1];
  logic [ID_W-1:0]  tag_id_d [SUM_LAT+1];
`ifdef SUM_ARB_OVF_EN
  logic [WIDTH-1:0] tag_a_q [SUM_LAT+1];
  logic [WIDTH-1:0] tag_a_d [SUM_LAT+1];
`endif
  logic [ENT_W-1:0] fifo_mem_q [RES_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Combinational controls
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic             issue;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head_entry;

  // Requester index (base + off) wrapped into 0..N_REQ-1; off is below N_REQ
  function automatic logic [ID_W-1:0] rr_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // FIFO pointer increment with wrap at RES_DEPTH (depth need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == RES_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Grant the first valid requester at or after rr_ptr, only while a result slot is free
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_valid[rr_add(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_add(rr_ptr_q, k);
      end
    end
    issue     = gnt_found && (credits_q != '0) && aresetn;
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  assign push       = tag_vld_q[SUM_LAT];
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;

`ifdef SUM_ARB_OVF_EN
  // A wrapped sum is smaller than either operand exactly when a carry occurred
  assign push_entry = {(sum_c < tag_a_q[SUM_LAT]), tag_id_q[SUM_LAT], sum_c};
  assign resp_ovf   = head_entry[ENT_W-1];
`else
  assign push_entry = {tag_id_q[SUM_LAT], sum_c};
`endif

  assign head_entry = fifo_mem_q[rd_ptr_q];
  assign resp_c     = head_entry[WIDTH-1:0];
  assign resp_id    = head_entry[WIDTH +: ID_W];
  assign sum_a      = sum_a_q;
  assign sum_b      = sum_b_q;

  // Issue path: operand registers, round-robin pointer and the ID tag pipeline
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sum_a_d  = sum_a_q;
    sum_b_d  = sum_b_q;
    if (issue) begin
      rr_ptr_d = rr_add(gnt_id, 1);
      sum_a_d  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
      sum_b_d  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    end
    tag_vld_d[0] = issue;
    tag_id_d[0]  = issue ? gnt_id : tag_id_q[0];
`ifdef SUM_ARB_OVF_EN
    tag_a_d[0]   = sum_a_d;
`endif
    for (int s = 1; s <= SUM_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
`ifdef SUM_ARB_OVF_EN
      tag_a_d[s]   = tag_a_q[s-1];
`endif
    end
  end

  // Result side: credit accounting and FIFO bookkeeping
  always_comb begin
    credits_d  = credits_q;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (issue && !pop)      credits_d = credits_q - CNT_W'(1);
    else if (pop && !issue) credits_d = credits_q + CNT_W'(1);
    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // State registers; reset discards every in-flight and buffered result
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rr_ptr_q  <= '0;
      credits_q <= CNT_W'(RES_DEPTH);
      sum_a_q   <= '0;
      sum_b_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s <= SUM_LAT; s++) begin
        tag_id_q[s] <= '0;
`ifdef SUM_ARB_OVF_EN
        tag_a_q[s]  <= '0;
`endif
      end
      for (int e = 0; e < RES_DEPTH; e++) fifo_mem_q[e] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      sum_a_q    <= sum_a_d;
      sum_b_q    <= sum_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
`ifdef SUM_ARB_OVF_EN
      tag_a_q    <= tag_a_d;
`endif
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_arbiter
// Purpose  : Self-checking bench for sum_arbiter with a registered adder model
//            and a transaction-level reference (credits, round-robin, FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;  // accept cycle to first cycle the result is visible

  logic           clk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   sum_a;
  logic [W-1:0]   sum_b;
  logic [W-1:0]   sum_c;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_c;
`ifdef SUM_ARB_OVF_EN
  logic           resp_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int id;
    int c;
    int ovf;
    int avail;
  } item_t;

  item_t        exp_q[$];
  int           grant_log[$];
  int           pop_id_log[$];
  int           pop_c_log[$];
  int           ptr;
  int           outstanding;
  int           total_acc;
  int           last_pop_id, last_pop_c, last_pop_ovf, last_pop_cyc, last_acc_cyc;
  logic [N-1:0] xfer;
  logic [N-1:0] oneshot;
  bit           rand_mode;
  logic [W-1:0] exp_sa, exp_sb;
  int           a0, a1;

  always #5 clk = ~clk;

  sum_arbiter #(.N_REQ(N), .WIDTH(W), .SUM_LAT(1), .RES_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .sum_a      (sum_a),
    .sum_b      (sum_b),
    .sum_c      (sum_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_c     (resp_c)
`ifdef SUM_ARB_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  // Shared registered adder (one cycle latency), reset with the arbiter
  always_ff @(posedge clk) begin
    if (!aresetn) sum_c <= '0;
    else          sum_c <= sum_a + sum_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Reference model evaluated once per cycle, away from the clock edge
  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    logic [W-1:0] a, b;
    int           g;
    bit           found;
    bit           exp_valid;
    item_t        it;
    exp_rdy = '0;
    found   = 1'b0;
    g       = 0;
    if (outstanding < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(ptr + k) % N]) begin
          found = 1'b1;
          g     = (ptr + k) % N;
        end
      end
    end
    if (found) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("sum_a", sum_a, exp_sa);
    check("sum_b", sum_b, exp_sb);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check("resp_valid", resp_valid, exp_valid);
    if (exp_valid) begin
      check("resp_id", resp_id, exp_q[0].id);
      check("resp_c", resp_c, exp_q[0].c);
`ifdef SUM_ARB_OVF_EN
      check("resp_ovf", resp_ovf, exp_q[0].ovf);
`endif
      if (resp_ready) begin
        last_pop_id  = exp_q[0].id;
        last_pop_c   = exp_q[0].c;
        last_pop_ovf = exp_q[0].ovf;
        last_pop_cyc = cyc;
        pop_id_log.push_back(exp_q[0].id);
        pop_c_log.push_back(exp_q[0].c);
        void'(exp_q.pop_front());
        outstanding--;
      end
    end
    xfer = '0;
    if (found) begin
      a        = req_a[g*W +: W];
      b        = req_b[g*W +: W];
      it.id    = g;
      it.c     = (int'(a) + int'(b)) % 256;
      it.ovf   = (int'(a) + int'(b) >= 256) ? 1 : 0;
      it.avail = cyc + LAT;
      exp_q.push_back(it);
      outstanding++;
      total_acc++;
      ptr          = (g + 1) % N;
      last_acc_cyc = cyc;
      grant_log.push_back(g);
      xfer[g]      = 1'b1;
      exp_sa       = a;
      exp_sb       = b;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer[i] && (rand_mode || oneshot[i])) req_valid[i] = 1'b0;
      if (rand_mode && !req_valid[i] && ($urandom_range(1) == 1)) begin
        req_valid[i] = 1'b1;
        set_req(i, int'($urandom_range(255)), int'($urandom_range(255)));
      end
    end
    if (rand_mode) resp_ready = ($urandom_range(2) != 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    req_valid = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst req_ready", req_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_id", resp_id, 0);
    check("rst resp_c", resp_c, 0);
    check("rst sum_a", sum_a, 0);
    check("rst sum_b", sum_b, 0);
`ifdef SUM_ARB_OVF_EN
    check("rst resp_ovf", resp_ovf, 0);
`endif
    exp_q.delete();
    ptr         = 0;
    outstanding = 0;
    exp_sa      = '0;
    exp_sb      = '0;
    aresetn     = 1'b1;
    req_valid   = '0;
    resp_ready  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    oneshot = '1; rand_mode = 1'b0; xfer = '0; total_acc = 0;
    exp_sa = '0; exp_sb = '0; ptr = 0; outstanding = 0;
    last_pop_id = -1; last_pop_c = -1; last_pop_ovf = -1; last_pop_cyc = 0; last_acc_cyc = 0;
    do_reset();

    // Single request from requester 2
    resp_ready = 1'b1; set_req(2, 3, 4); req_valid = 4'b0100;
    a0 = total_acc;
    run(6);
    check("single accepts", total_acc - a0, 1);
    check("single id", last_pop_id, 2);
    check("single c", last_pop_c, 7);
    check("single latency", last_pop_cyc - last_acc_cyc, 3);

    // All four valid straight out of reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i, 10);
    resp_ready = 1'b1; req_valid = '1;
    grant_log.delete(); pop_id_log.delete(); pop_c_log.delete();
    run(10);
    check("simul grants", grant_log.size(), 4);
    check("simul pops", pop_c_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("simul grant order", grant_log[k], k);
      check("simul resp id", pop_id_log[k], k);
      check("simul resp c", pop_c_log[k], 10 + k);
    end

    // Backpressure: credits cap acceptance at DEPTH
    resp_ready = 1'b0; oneshot = '0; req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 3 * i, i);
    a0 = total_acc;
    run(8);
    check("bp accepts", total_acc - a0, DEPTH);
    check("bp ready low", req_ready, 0);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    a1 = total_acc;
    check("bp no grant in pop cycle", a1 - a0, DEPTH);
    cycle();
    check("bp grant after pop", total_acc - a1, 1);
    req_valid = '0; oneshot = '1; resp_ready = 1'b1;
    run(10);

    // Wrap-around arithmetic
    set_req(0, 200, 100); req_valid = 4'b0001;
    run(6);
    check("wrap id", last_pop_id, 0);
    check("wrap c", last_pop_c, 44);
    check("wrap ovf model", last_pop_ovf, 1);
    set_req(1, 100, 27); req_valid = 4'b0010;
    run(6);
    check("nowrap c", last_pop_c, 127);
    check("nowrap ovf model", last_pop_ovf, 0);

    // Fairness between two continuously valid requesters
    grant_log.delete();
    set_req(0, 1, 1); set_req(3, 2, 2);
    oneshot = '0; req_valid = 4'b1001;
    run(8);
    req_valid = '0; oneshot = '1;
    check("fair enough grants", grant_log.size() >= 4, 1);
    check("fair req3 early", (grant_log[0] == 3) || (grant_log[1] == 3), 1);
    for (int k = 0; k < 3; k++) begin
      check("fair alternate", grant_log[k] != grant_log[k+1], 1);
      check("fair members", (grant_log[k] == 0) || (grant_log[k] == 3), 1);
    end
    run(8);

    // Reset with two results buffered and two in flight
    resp_ready = 1'b0; oneshot = '1;
    for (int i = 0; i < N; i++) set_req(i, 50 + i, 60);
    req_valid = '1;
    a0 = total_acc;
    run(4);
    check("mid accepts", total_acc - a0, 4);
    do_reset();
    resp_ready = 1'b1;
    run(6);
    resp_ready = 1'b0; oneshot = '0; req_valid = '1;
    a0 = total_acc;
    run(8);
    check("post-reset credits", total_acc - a0, DEPTH);
    req_valid = '0; oneshot = '1; resp_ready = 1'b1;
    run(8);
    set_req(1, 5, 6); req_valid = 4'b0010;
    run(6);
    check("post-reset id", last_pop_id, 1);
    check("post-reset c", last_pop_c, 11);

    // Randomized traffic with random backpressure
    rand_mode = 1'b1;
    run(400);
    rand_mode = 1'b0; req_valid = '0; resp_ready = 1'b1;
    run(12);
    check("drain empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_arbiter.md
# sum_arbiter

Round-robin scheduler that shares one registered `sum` adder instance between N_REQ requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues at most one pair per cycle to the adder, tracks the in-flight requester ID alongside the adder pipeline, and returns tagged results through a result FIFO with valid/ready backpressure. It sits between the requesting datapath blocks and the `sum` instance, and shares `clk`/`aresetn` with that instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width; must match the `sum` instance
- SUM_LAT, 1, cycles from `sum_a`/`sum_b` stable to `sum_c` valid
- RES_DEPTH, 4, result FIFO entries (≥2)
- clk  input  1  clock, all logic on rising edge
- aresetn  input  1  reset, synchronous, active-low
- req_valid  input  N_REQ  per-requester operand valid
- req_ready  output  N_REQ  per-requester grant; one-hot or zero
- req_a  input  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B, same packing
- sum_a  output  WIDTH  adder operand A (registered)
- sum_b  output  WIDTH  adder operand B (registered)
- sum_c  input  WIDTH  adder result
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  $clog2(N_REQ)  requester that issued the result
- resp_c  output  WIDTH  result, (a+b) mod 2^WIDTH
- resp_ovf  output  1  carry-out of the addition; present only with SUM_ARB_OVF_EN

## Operation
- Transfer on requester i occurs when req_valid[i] && req_ready[i]. Requesters hold valid and operands stable until the transfer.
- Arbitration is combinational from registered state. Candidate set is {i : req_valid[i]}; grant goes to the first candidate at or after `rr_ptr`, scanning upward with wrap. A grant is issued only if `credits > 0`.
- After a grant to i, `rr_ptr <= (i+1) mod N_REQ`. With no grant, `rr_ptr` holds.
- Issue: granted operands are registered into `sum_a`/`sum_b`. The ID is pushed into a SUM_LAT+1 stage tag pipeline with a valid bit. `sum_a`/`sum_b` hold their last value when idle.
- Capture: when the tag pipeline output is valid, {id, sum_c} is written to the result FIFO.
- Credits: `credits` starts at RES_DEPTH.
  - Decrement on issue; increment on FIFO pop (resp_valid && resp_ready).
  - Simultaneous issue and pop leaves it unchanged.
  - Free slots are reserved at issue, so the FIFO never overflows and no in-flight result is dropped.
- FIFO is first-in first-out. resp_valid = !empty. resp_* show the head entry and stay stable while resp_valid && !resp_ready.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

## Timing
- Reset (aresetn=0 at a rising edge) sets:
  - req_ready=0, resp_valid=0, resp_id=0, resp_c=0, resp_ovf=0, sum_a=0, sum_b=0
  - rr_ptr=0, credits=RES_DEPTH, FIFO empty, tag pipeline cleared
  - Reset mid-operation discards all in-flight and buffered results. The first cycle after release behaves as fresh.
- Request accepted in cycle T gives: sum_a/sum_b valid in T+1, sum_c valid in T+1+SUM_LAT, FIFO write at the end of that cycle, resp_valid earliest in T+2+SUM_LAT. With the defaults, the minimum latency is 3 cycles.
- Throughput is one issue per cycle while credits remain and the consumer keeps resp_ready=1.
- With resp_ready held low, exactly RES_DEPTH requests are accepted, then all req_ready stay 0 until a pop. A pop in cycle P allows a grant in P+1.
- A requester continuously valid is granted at least once every N_REQ grants.

## Configuration
- SUM_ARB_OVF_EN defined:
  - each FIFO entry stores one extra bit: ovf = (sum_c < stored operand A), i.e. the carry-out. Operand A is carried in the tag pipeline.
  - resp_ovf output is present.
- SUM_ARB_OVF_EN undefined: resp_ovf port, its storage and the operand-A tag field are absent. All other behaviour is identical.

## Test plan
- Single request: req 2 with a=3, b=4, resp_ready=1 → resp_valid in cycle T+3 with resp_id=2, resp_c=7; req_ready[2] high for one cycle only.
- Simultaneous requests: all four valid from reset, operands a=i, b=10 → grants in order 0,1,2,3 on consecutive cycles; responses id 0..3 with c=10..13 in order.
- Backpressure: resp_ready=0, all valid → exactly 4 accepts, then req_ready=0. Raise resp_ready for one cycle → one pop, one new grant the next cycle.
- Wrap-around: a=200, b=100 → resp_c=44, resp_ovf=1 (with SUM_ARB_OVF_EN). a=100, b=27 → resp_c=127, resp_ovf=0.
- Fairness: req 0 continuously valid, req 3 valid → req 3 granted within 2 grants; grants alternate 0,3,0,3.
- Reset mid-operation: drive aresetn low with 2 results in flight and 2 buffered → all outputs reach reset values, credits=4, no stale response after release; a new request returns correctly.
